// File: rtl/csa_mult_pkg.sv
// csa_mult_pkg: shared types and helpers for the carry-save sequential multiplier
// Contents: state_t FSM encoding, pp_row() partial-product row builder,
//           bw_const() Baugh-Wooley correction constant.
package csa_mult_pkg;

  typedef enum logic [1:0] {IDLE, REDUCE, RESOLVE, DONE} state_t;

  // Row i of the a*b partial-product array, shifted into place. Operands are
  // zero-extended to 32 bits; the caller truncates the result to 2*w bits.
  // In signed mode the Baugh-Wooley terms are inverted: bit w-1 of rows below
  // w-1, and bits 0..w-2 of row w-1.
  function automatic logic [63:0] pp_row(input logic [31:0] a, input logic [31:0] b,
                                         input int i, input int w, input logic sgn);
    logic [63:0] r;
    logic bit_v;
    r = '0;
    for (int j = 0; j < 32; j++) begin
      if (j < w) begin
        bit_v = a[j] & b[i];
        if (sgn && ((i < w - 1 && j == w - 1) || (i == w - 1 && j < w - 1)))
          bit_v = ~bit_v;
        r[j] = bit_v;
      end
    end
    return r << i;
  endfunction

  // Constant that turns the inverted Baugh-Wooley terms into a two's-complement product.
  function automatic logic [63:0] bw_const(input int w);
    return (64'd1 << w) | (64'd1 << (2 * w - 1));
  endfunction

endpackage

// File: rtl/csa_row_3to2.sv
// csa_row_3to2: N-bit 3:2 carry-save compressor row
// Ports: x, y, z (N-bit addends) -> s (bitwise sum), c (carry, shifted left one, MSB carry dropped)
module csa_row_3to2 #(
  parameter int N = 16
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] z,
  output logic [N-1:0] s,
  output logic [N-1:0] c
);
  assign s = x ^ y ^ z;
  assign c = ((x & y) | (x & z) | (y & z)) << 1;
endmodule

// File: rtl/csa_seq_multiplier.sv
// csa_seq_multiplier: multi-cycle WIDTH x WIDTH multiplier, RPC carry-save rows per clock
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready + a, b operand handshake;
//        out_valid/out_ready + product (2*WIDTH, held until accepted); busy (state != IDLE).
// Build option: define SIGNED_MODE_EN for two's-complement (Baugh-Wooley) operation.
module csa_seq_multiplier
  import csa_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int RPC   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);
  localparam int W2 = 2 * WIDTH;
  localparam int IW = $clog2(WIDTH + 1);
`ifdef SIGNED_MODE_EN
  localparam logic SGN = 1'b1;
  localparam logic [W2-1:0] S_INIT = W2'(bw_const(WIDTH));
`else
  localparam logic SGN = 1'b0;
  localparam logic [W2-1:0] S_INIT = '0;
`endif

  if (!(RPC == 1 || RPC == 2 || RPC == 4) || (WIDTH % RPC) != 0 || WIDTH < 4 || WIDTH > 32) begin : g_bad_params
    $error("csa_seq_multiplier: illegal WIDTH/RPC combination");
  end

  state_t state, state_n;
  logic [WIDTH-1:0] a_r, b_r;
  logic [W2-1:0] s_r, c_r;
  logic [IW-1:0] idx;
  logic last;
  logic [RPC:0][W2-1:0] s_ch, c_ch;
  logic [RPC-1:0][W2-1:0] rows;

  assign s_ch[0] = s_r;
  assign c_ch[0] = c_r;
  assign last = (idx + IW'(RPC)) == IW'(WIDTH);

  for (genvar k = 0; k < RPC; k++) begin : g_chain
    assign rows[k] = W2'(pp_row(32'(a_r), 32'(b_r), int'(idx) + k, WIDTH, SGN));
    csa_row_3to2 #(.N(W2)) u_row (
      .x(s_ch[k]),
      .y(c_ch[k]),
      .z(rows[k]),
      .s(s_ch[k+1]),
      .c(c_ch[k+1])
    );
  end

  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_n;

  always_comb
    state_n = (state == IDLE)   ? (in_valid ? REDUCE : IDLE) :
              (state == REDUCE) ? (last ? RESOLVE : REDUCE) :
              (state == RESOLVE) ? DONE :
              (out_ready ? IDLE : DONE);

  always_comb begin
    in_ready  = rst_n && state == IDLE;
    out_valid = state == DONE;
    busy      = state != IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      s_r     <= '0;
      c_r     <= '0;
      idx     <= '0;
      product <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        a_r <= a;
        b_r <= b;
        s_r <= S_INIT;
        c_r <= '0;
        idx <= '0;
      end
      if (state == REDUCE) begin
        s_r <= s_ch[RPC];
        c_r <= c_ch[RPC];
        idx <= idx + IW'(RPC);
      end
      if (state == RESOLVE)
        product <= s_r + c_r;
    end
  end
endmodule

// File: tb/tb_csa_seq_multiplier.sv
// tb_csa_seq_multiplier: scoreboard bench for csa_seq_multiplier (8x8/RPC=2 plus 16-bit RPC sweep)
module tb_csa_seq_multiplier;
  localparam int W = 8;
  localparam int R = 2;
  localparam int LAT = W / R + 1;
  localparam int PER = W / R + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0] a, b;
  logic [2*W-1:0] product;

  logic s_v;
  logic [15:0] s_a, s_b;
  logic [2:0] pr, pv, pb;
  logic [31:0] pq [3];

  logic [63:0] q [$];
  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int lat, gap, prev, t;
  int sl [3];
  logic [31:0] sp [3];
  logic [W-1:0] da [5];
  logic [W-1:0] db [5];
  logic [15:0] dexp [5];
  int nd;

  csa_seq_multiplier #(.WIDTH(W), .RPC(R)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  for (genvar g = 0; g < 3; g++) begin : g_sw
    csa_seq_multiplier #(.WIDTH(16), .RPC(1 << g)) u (
      .clk(clk), .rst_n(rst_n), .in_valid(s_v), .in_ready(pr[g]),
      .a(s_a), .b(s_b), .out_valid(pv[g]), .out_ready(1'b1),
      .product(pq[g]), .busy(pb[g])
    );
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input int w);
    longint sx, sy;
    logic [63:0] m;
    m = (64'd1 << (2 * w)) - 64'd1;
    sx = longint'(x);
    sy = longint'(y);
`ifdef SIGNED_MODE_EN
    if (x[w-1]) sx = sx - (longint'(1) << w);
    if (y[w-1]) sy = sy - (longint'(1) << w);
`endif
    return 64'(sx * sy) & m;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
    chk("in_ready_idle", in_ready, 1);
    a = x;
    b = y;
    in_valid = 1'b1;
    tick();
    q.push_back(ref_mul(32'(x), 32'(y), W));
    in_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic wait_out(output int l, input bit noise);
    l = 0;
    while (!out_valid && l < 100) begin
      if (noise) begin
        in_valid = 1'($urandom);
        a = W'($urandom);
        b = W'($urandom);
      end
      tick();
      l++;
      if (busy) chk("no_accept_busy", in_ready, 0);
    end
    in_valid = 1'b0;
    chk("out_valid_timeout", out_valid, 1);
  endtask

  task automatic take(input bit hold);
    chk("sb_nonempty", q.size() > 0, 1);
    if (q.size() > 0) chk("product", product, q.pop_front());
    out_ready = 1'b1;
    tick();
    out_ready = hold;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_after", in_ready, 1);
  endtask

  initial begin
`ifdef SIGNED_MODE_EN
    da = '{8'h80, 8'hFD, 8'h7F, 8'hFF, 8'h00};
    db = '{8'hFF, 8'h05, 8'h7F, 8'hFF, 8'hC8};
    dexp = '{16'h0080, 16'hFFF1, 16'h3F01, 16'h0001, 16'h0000};
    nd = 5;
`else
    da = '{8'hFF, 8'h01, 8'h00, 8'h80, 8'h00};
    db = '{8'hFF, 8'h01, 8'hC8, 8'hFF, 8'h00};
    dexp = '{16'hFE01, 16'h0001, 16'h0000, 16'h7F80, 16'h0000};
    nd = 4;
`endif
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    s_v = 1'b0;
    s_a = '0;
    s_b = '0;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_product", product, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1);
    chk("sweep_in_ready", pr, 3'b111);

    for (int i = 0; i < nd; i++) begin
      send(da[i], db[i]);
      wait_out(lat, 1'b0);
      chk("latency", lat, LAT);
      chk("product_const", product, dexp[i]);
      take(1'b0);
    end

    send(8'h5A, 8'h3C);
    wait_out(lat, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      tick();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_product", product, q[0]);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    take(1'b0);
    repeat (8) tick();
    chk("bp_no_extra_result", out_valid, 0);
    chk("bp_idle", busy, 0);

    send(8'h12, 8'h34);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_product", product, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("midrst_release_in_ready", in_ready, 1);
    q.delete();
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("midrst_no_stale", out_valid, 0);
    end

    s_a = 16'hFFFF;
    s_b = 16'hFFFF;
    s_v = 1'b1;
    chk("sweep_ready", pr, 3'b111);
    tick();
    s_v = 1'b0;
    for (int g = 0; g < 3; g++) begin
      sl[g] = 0;
      sp[g] = '0;
    end
    for (int n = 1; n <= 30; n++) begin
      tick();
      for (int g = 0; g < 3; g++)
        if (pv[g] && sl[g] == 0) begin
          sl[g] = n;
          sp[g] = pq[g];
        end
    end
    for (int g = 0; g < 3; g++) begin
      chk("sweep_latency", sl[g], 16 / (1 << g) + 1);
      chk("sweep_product", sp[g], ref_mul(32'hFFFF, 32'hFFFF, 16));
    end
    chk("sweep_busy", pb, 3'b000);

    out_ready = 1'b1;
    prev = -1;
    for (int i = 0; i < 1000; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      t = cyc;
      if (gap == 0 && prev >= 0) chk("throughput", t - prev, PER);
      prev = t;
      send(W'($urandom), W'($urandom));
      wait_out(lat, 1'b1);
      chk("rand_latency", lat, LAT);
      take(1'b1);
    end
    chk("sb_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
